// File: rtl/matrix_bcm_pkg.sv
// Shared types and helpers for the binary-code-modulated LED matrix driver.
package matrix_bcm_pkg;

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, HOLD} scan_state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_LOW, PH_HIGH, PH_LATCH} shift_phase_e;

  localparam int MAX_PIX_W = 24;

  function automatic int shift_len(input int rows, input int cols);
    return rows + 3 * cols;
  endfunction

  function automatic int addr_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  // comp 0 = R (top field), 1 = G, 2 = B
  function automatic logic pix_bit(input logic [MAX_PIX_W-1:0] pix, input int bpc,
                                   input int comp, input int plane);
    return pix[(2 - comp) * bpc + plane];
  endfunction

  function automatic logic [MAX_PIX_W-1:0] merge_pixel(input logic [MAX_PIX_W-1:0] old_pix,
                                                       input logic [31:0] wdata,
                                                       input logic [3:0] sel,
                                                       input int pix_w);
    logic [MAX_PIX_W-1:0] res;
    res = old_pix;
    for (int i = 0; i < MAX_PIX_W; i++) begin
      if (i < pix_w && sel[i / 8]) res[i] = wdata[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/matrix_shifter.sv
// Serialises one row/plane word MSB-first with a divided shift clock, then pulses latch.
module matrix_shifter
  import matrix_bcm_pkg::*;
#(
  parameter int LEN     = 32,
  parameter int CLK_DIV = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start_i,
  input  logic [LEN-1:0] data_i,
  output logic           shift_done_o,
  output logic           done_o,
  output logic           sclk_o,
  output logic           latch_o,
  output logic           mosi_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(LEN);

  shift_phase_e   phase_q, phase_d;
  logic [LEN-1:0] sreg_q, sreg_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [DW-1:0]  div_q, div_d;
  logic           div_end;

  assign div_end = (div_q == DW'(CLK_DIV - 1));

  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so no latch is inferred; the clocked block below uses non-blocking '<=' only.
  always_comb begin
    phase_d      = phase_q;
    sreg_d       = sreg_q;
    bit_d        = bit_q;
    div_d        = div_end ? '0 : div_q + 1'b1;
    shift_done_o = 1'b0;
    done_o       = 1'b0;
    unique case (phase_q)
      PH_IDLE:  div_d = '0;
      PH_LOW:   if (div_end) phase_d = PH_HIGH;
      PH_HIGH: begin
        if (div_end) begin
          sreg_d = {sreg_q[LEN-2:0], 1'b0};
          if (bit_q == BW'(LEN - 1)) begin
            phase_d      = PH_LATCH;
            shift_done_o = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            phase_d = PH_LOW;
          end
        end
      end
      PH_LATCH: begin
        if (div_end) begin
          phase_d = PH_IDLE;
          done_o  = 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
    if (start_i) begin
      phase_d = PH_LOW;
      sreg_d  = data_i;
      bit_d   = '0;
      div_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      phase_q <= phase_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  // Decoded straight from the phase register so reset drops the pins at once.
  assign sclk_o  = (phase_q == PH_HIGH);
  assign latch_o = (phase_q == PH_LATCH);
  assign mosi_o  = ((phase_q == PH_LOW) || (phase_q == PH_HIGH)) && sreg_q[LEN-1];

endmodule

// File: rtl/matrix_bcm.sv
// LED matrix driver: pipelined Wishbone framebuffer plus row/bit-plane BCM scan FSM.
module matrix_bcm
  import matrix_bcm_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int BPC        = 4,
  parameter int CLK_DIV    = 2,
  parameter int BASE_TICKS = 64,
  localparam int AW        = addr_width(ROWS, COLS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    i_refresh_speed,
  output logic          o_matrix_clk,
  output logic          o_matrix_latch,
  output logic          o_matrix_mosi,
  output logic          o_frame_strobe,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [3:0]    i_wb_sel,
  input  logic [31:0]   i_wb_wdata,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [31:0]   o_wb_rdata
);

  localparam int NPIX = ROWS * COLS;
  localparam int PW   = 3 * BPC;
  localparam int LEN  = shift_len(ROWS, COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int PLW  = (BPC > 1) ? $clog2(BPC) : 1;

  logic [PW-1:0]        fb_q [NPIX];
  logic                 req, addr_ok;
  logic [MAX_PIX_W-1:0] wr_pix;
  logic                 ack_q;
  logic [31:0]          rdata_q;

  assign req     = i_wb_cyc & i_wb_stb;
  assign addr_ok = (32'(i_wb_addr) < 32'(NPIX));
  assign wr_pix  = merge_pixel(MAX_PIX_W'(fb_q[i_wb_addr]), i_wb_wdata, i_wb_sel, PW);

  // NOTE: the framebuffer is reset explicitly because it must read back as zeros
  // after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPIX; i++) fb_q[i] <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (req && i_wb_we && addr_ok) fb_q[i_wb_addr] <= wr_pix[PW-1:0];
      ack_q   <= req;
      rdata_q <= (req && !i_wb_we && addr_ok) ? 32'(fb_q[i_wb_addr]) : '0;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_stall = 1'b0;
  assign o_wb_rdata = rdata_q;

  scan_state_e    state_q, state_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PLW-1:0] plane_q, plane_d;
  logic [31:0]    hold_q, hold_d;
  logic           strobe_q, strobe_d;
  logic           start, shift_done, sh_done;
  logic [LEN-1:0] load_bits;

  // Row one-hot on top, then columns high-to-low as {R,G,B} of the current plane.
  always_comb begin
    load_bits = '0;
    load_bits[3 * COLS + int'(row_q)] = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      for (int k = 0; k < 3; k++) begin
        load_bits[3 * c + 2 - k] =
          pix_bit(MAX_PIX_W'(fb_q[int'(row_q) * COLS + c]), BPC, k, int'(plane_q));
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    plane_d  = plane_q;
    hold_d   = hold_q;
    strobe_d = 1'b0;
    start    = 1'b0;
    unique case (state_q)
      LOAD: begin
        start   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (shift_done) state_d = LATCH;
      LATCH: begin
        if (sh_done) begin
          state_d = HOLD;
          hold_d  = (32'(BASE_TICKS) << (32'(plane_q) + 32'(i_refresh_speed))) - 32'd1;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d = LOAD;
          if (plane_q == PLW'(BPC - 1)) begin
            plane_d = '0;
            if (row_q == RW'(ROWS - 1)) begin
              row_d    = '0;
              strobe_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LOAD;
      row_q    <= '0;
      plane_q  <= '0;
      hold_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      plane_q  <= plane_d;
      hold_q   <= hold_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_frame_strobe = strobe_q;

  matrix_shifter #(
    .LEN     (LEN),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start),
    .data_i       (load_bits),
    .shift_done_o (shift_done),
    .done_o       (sh_done),
    .sclk_o       (o_matrix_clk),
    .latch_o      (o_matrix_latch),
    .mosi_o       (o_matrix_mosi)
  );

endmodule

// File: tb/tb_matrix_bcm.sv
// Self-checking bench for matrix_bcm: bus behaviour, serial stream, BCM timing, reset.
module tb_matrix_bcm;

  localparam int ROWS = 8, COLS = 8, BPC = 4, CLK_DIV = 2, BASE_TICKS = 64;
  localparam int NPIX = ROWS * COLS, PW = 3 * BPC, LEN = ROWS + 3 * COLS, AW = 6;
  localparam int S_AW = 4;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [1:0]    speed = 2'd0;
  logic          sclk, latch, mosi, fstrobe;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    sel = '0;
  logic [31:0]   wdata = '0;
  logic          ack, stall;
  logic [31:0]   rdata;

  logic            s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
  logic [S_AW-1:0] s_addr = '0;
  logic [3:0]      s_sel = '0;
  logic [31:0]     s_wdata = '0;
  logic            s_ack, s_stall, s_sclk, s_latch, s_mosi, s_fstrobe;
  logic [31:0]     s_rdata;

  int errors = 0, checks = 0;
  int unsigned cycle = 0;
  logic [PW-1:0] model_fb [NPIX];

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  matrix_bcm #(.ROWS(ROWS), .COLS(COLS), .BPC(BPC), .CLK_DIV(CLK_DIV), .BASE_TICKS(BASE_TICKS)) dut (
    .clk(clk), .reset_n(reset_n), .i_refresh_speed(speed),
    .o_matrix_clk(sclk), .o_matrix_latch(latch), .o_matrix_mosi(mosi), .o_frame_strobe(fstrobe),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_sel(sel),
    .i_wb_wdata(wdata), .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_rdata(rdata));

  matrix_bcm #(.ROWS(3), .COLS(3), .BPC(2), .CLK_DIV(1), .BASE_TICKS(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .i_refresh_speed(2'd0),
    .o_matrix_clk(s_sclk), .o_matrix_latch(s_latch), .o_matrix_mosi(s_mosi), .o_frame_strobe(s_fstrobe),
    .i_wb_cyc(s_cyc), .i_wb_stb(s_stb), .i_wb_we(s_we), .i_wb_addr(s_addr), .i_wb_sel(s_sel),
    .i_wb_wdata(s_wdata), .o_wb_ack(s_ack), .o_wb_stall(s_stall), .o_wb_rdata(s_rdata));

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < NPIX; i++) model_fb[i] = '0;
  endtask

  task automatic model_write(input int a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) if (s[b]) mask[b*8 +: 8] = 8'hFF;
    mask &= (32'd1 << PW) - 32'd1;
    model_fb[a] = PW'((32'(model_fb[a]) & ~mask) | (d & mask));
  endtask

  function automatic logic [LEN-1:0] expected_stream(input int row, input int plane);
    logic [LEN-1:0] s;
    logic [PW-1:0]  pix;
    s = '0;
    for (int r = ROWS - 1; r >= 0; r--) s = {s[LEN-2:0], (r == row)};
    for (int c = COLS - 1; c >= 0; c--) begin
      pix = model_fb[row * COLS + c];
      for (int comp = 2; comp >= 0; comp--) s = {s[LEN-2:0], pix[comp * BPC + plane]};
    end
    return s;
  endfunction

  // ---------------- bus and observation helpers ----------------
  task automatic bus_write(input int a, input logic [3:0] s, input logic [31:0] d, output logic got_ack);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = AW'(a); sel = s; wdata = d;
    model_write(a, s, d);
    @(posedge clk); #1;
    got_ack = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic got_ack, output logic [31:0] got);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = AW'(a); sel = 4'hF;
    @(posedge clk); #1;
    got_ack = ack; got = rdata;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic s_write(input int a, input logic [3:0] s, input logic [31:0] d, output logic got_ack);
    @(posedge clk); #1;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_addr = S_AW'(a); s_sel = s; s_wdata = d;
    @(posedge clk); #1;
    got_ack = s_ack;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
  endtask

  task automatic s_read(input int a, output logic got_ack, output logic [31:0] got);
    @(posedge clk); #1;
    s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = S_AW'(a); s_sel = 4'hF;
    @(posedge clk); #1;
    got_ack = s_ack; got = s_rdata;
    s_cyc = 1'b0; s_stb = 1'b0;
  endtask

  task automatic wait_strobe(output int unsigned t, output bit ok);
    ok = 1'b0; t = 0;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      if (fstrobe) begin ok = 1'b1; t = cycle; break; end
    end
  endtask

  task automatic wait_latch_rise(output int unsigned t, output bit ok);
    logic prev;
    prev = latch; ok = 1'b0; t = 0;
    for (int n = 0; n < 5000; n++) begin
      @(posedge clk); #1;
      if (latch && !prev) begin ok = 1'b1; t = cycle; break; end
      prev = latch;
    end
  endtask

  task automatic capture_stream(output logic [LEN-1:0] bits, output int rises,
                                output int latch_cycles, output int clk_in_latch, output bit ok);
    logic prev;
    prev = sclk; bits = '0; rises = 0; latch_cycles = 0; clk_in_latch = 0; ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (sclk && !prev) begin bits = {bits[LEN-2:0], mosi}; rises++; end
      prev = sclk;
      if (latch) begin
        latch_cycles++;
        if (sclk) clk_in_latch++;
      end else if (latch_cycles > 0) begin
        ok = 1'b1; break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic a; logic [31:0] d;
    reset_n = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 6'd3; sel = 4'hF; wdata = 32'hFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sclk, latch, mosi, fstrobe, ack, stall} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000", {sclk, latch, mosi, fstrobe, ack, stall});
    checks++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 00000000", rdata);
    if (rdata !== 32'h0 || {sclk, latch, mosi, fstrobe, ack, stall} !== 6'b0) errors++;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_clear();
    bus_read(3, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL reset_fb_zero: got ack=%b data=%h expected ack=1 data=00000000", a, d);
    end
  endtask

  task automatic test_write_read();
    logic a; logic [31:0] d;
    bus_write(9, 4'b0111, 32'h00000A5C, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL write_ack: got %b expected 1", a); end
    bus_read(9, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'(model_fb[9])) begin
      errors++; $display("FAIL read_back9: got ack=%b data=%h expected ack=1 data=%h", a, d, model_fb[9]);
    end
  endtask

  task automatic test_byte_sel();
    logic a; logic [31:0] d;
    bus_write(5, 4'b1111, 32'hFFFF_F123, a);
    bus_write(5, 4'b0001, 32'h0000_00FF, a);
    bus_read(5, a, d);
    checks++;
    if (d !== 32'h0000_01FF || d !== 32'(model_fb[5])) begin
      errors++; $display("FAIL byte_sel: got %h expected 000001ff", d);
    end
  endtask

  task automatic test_random_bus();
    logic p_req, p_rd;
    logic [31:0] p_exp;
    int a;
    p_req = 1'b0; p_rd = 1'b0; p_exp = '0;
    for (int n = 0; n <= 200; n++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== p_req) begin errors++; $display("FAIL pipe_ack: cycle %0d got %b expected %b", n, ack, p_req); end
      if (p_rd) begin
        checks++;
        if (rdata !== p_exp) begin errors++; $display("FAIL pipe_rdata: cycle %0d got %h expected %h", n, rdata, p_exp); end
      end
      if (n == 200) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; break; end
      p_req = ($urandom_range(0, 3) != 0);
      if (p_req) begin cyc = 1'b1; stb = 1'b1; end
      else begin cyc = 1'($urandom_range(0, 1)); stb = ~cyc; end
      we = 1'($urandom_range(0, 1));
      a = $urandom_range(0, NPIX - 1);
      addr = AW'(a); sel = 4'($urandom); wdata = $urandom;
      p_rd = p_req && !we;
      if (p_rd) p_exp = 32'(model_fb[a]);
      if (p_req && we) model_write(a, sel, wdata);
    end
  endtask

  task automatic test_stream_single();
    logic a; logic [LEN-1:0] bits; int rises, lat, cil; bit ok; int unsigned t;
    for (int i = 0; i < NPIX; i++) bus_write(i, 4'hF, 32'h0, a);
    bus_write(7, 4'hF, 32'h0000_0F00, a);
    wait_strobe(t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL strobe_timeout_single: got none expected strobe"); return; end
    capture_stream(bits, rises, lat, cil, ok);
    checks++;
    if (!ok || bits !== 32'h0180_0000 || bits !== expected_stream(0, 0)) begin
      errors++; $display("FAIL stream_row0_p0: got %h expected 01800000", bits);
    end
    checks++;
    if (rises !== 32 || lat !== CLK_DIV || cil !== 0) begin
      errors++; $display("FAIL stream_framing: got rises=%0d latch=%0d clk_in_latch=%0d expected 32/%0d/0", rises, lat, cil, CLK_DIV);
    end
  endtask

  task automatic test_stream_random();
    logic a; logic [LEN-1:0] bits, exp; int rises, lat, cil; bit ok; int unsigned t;
    for (int i = 0; i < 2 * COLS; i++) bus_write(i, 4'hF, $urandom, a);
    wait_strobe(t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL strobe_timeout_random: got none expected strobe"); return; end
    for (int k = 0; k < BPC + 1; k++) begin
      exp = (k < BPC) ? expected_stream(0, k) : expected_stream(1, 0);
      // Bus write landing mid-SHIFT must not disturb the word already in flight.
      if (k == 0) bus_write(0, 4'hF, ~32'(model_fb[0]), a);
      capture_stream(bits, rises, lat, cil, ok);
      checks++;
      if (!ok || bits !== exp || rises !== LEN) begin
        errors++; $display("FAIL stream_scan%0d: got %h (%0d rises) expected %h", k, bits, rises, exp);
      end
    end
  endtask

  task automatic test_hold_speed();
    int unsigned t0, r4, r5, r6; bit ok;
    int overhead;
    overhead = CLK_DIV + 1 + LEN * 2 * CLK_DIV;
    wait_strobe(t0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL strobe_timeout_hold: got none expected strobe"); return; end
    speed = 2'b01;
    for (int k = 0; k < 4; k++) wait_latch_rise(r4, ok);
    repeat (10) @(posedge clk);
    #1 speed = 2'b11;
    wait_latch_rise(r5, ok);
    wait_latch_rise(r6, ok);
    checks++;
    if (!ok || int'(r5 - r4) - overhead !== (BASE_TICKS << 4)) begin
      errors++; $display("FAIL hold_plane3_speed1: got %0d expected %0d", int'(r5 - r4) - overhead, BASE_TICKS << 4);
    end
    checks++;
    if (!ok || int'(r6 - r5) - overhead !== (BASE_TICKS << 3)) begin
      errors++; $display("FAIL hold_plane0_speed3: got %0d expected %0d", int'(r6 - r5) - overhead, BASE_TICKS << 3);
    end
    speed = 2'b00;
  endtask

  task automatic test_frame_period();
    int unsigned t0, t1; bit ok0, ok1; int exp;
    exp = 0;
    for (int r = 0; r < ROWS; r++)
      for (int b = 0; b < BPC; b++) exp += 1 + LEN * 2 * CLK_DIV + CLK_DIV + (BASE_TICKS << b);
    speed = 2'b00;
    wait_strobe(t0, ok0);
    @(posedge clk); #1;
    checks++;
    if (fstrobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", fstrobe); end
    wait_strobe(t1, ok1);
    checks++;
    if (!ok0 || !ok1 || int'(t1 - t0) !== exp) begin
      errors++; $display("FAIL frame_period: got %0d expected %0d", int'(t1 - t0), exp);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic a; logic [31:0] d; logic [LEN-1:0] bits; int rises, lat, cil; bit ok;
    bus_write(9, 4'hF, 32'hFFF, a);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (sclk) begin ok = 1'b1; break; end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || {sclk, latch, mosi, fstrobe, ack} !== 5'b0) begin
      errors++; $display("FAIL reset_mid_shift: got %b expected 00000", {sclk, latch, mosi, fstrobe, ack});
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_clear();
    capture_stream(bits, rises, lat, cil, ok);
    checks++;
    if (!ok || bits !== expected_stream(0, 0) || rises !== LEN) begin
      errors++; $display("FAIL restart_row0_p0: got %h expected %h", bits, expected_stream(0, 0));
    end
    bus_read(9, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL fb_cleared_addr9: got ack=%b data=%h expected ack=1 data=00000000", a, d);
    end
  endtask

  task automatic test_out_of_range();
    logic a; logic [31:0] d;
    s_write(8, 4'hF, 32'hFFFF_FF2A, a);
    s_read(8, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h2A) begin errors++; $display("FAIL small_last_pixel: got %h expected 0000002a", d); end
    s_write(9, 4'hF, 32'h3F, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL oor_write_ack: got %b expected 1", a); end
    s_read(9, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL oor_read9: got ack=%b data=%h expected ack=1 data=0", a, d); end
    s_read(1, a, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL oor_no_alias: got %h expected 00000000", d); end
    s_read(15, a, d);
    checks++;
    if (a !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL oor_read15: got ack=%b data=%h expected ack=1 data=0", a, d); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_byte_sel();
    test_random_bus();
    test_stream_single();
    test_stream_random();
    test_hold_speed();
    test_frame_period();
    test_reset_mid_shift();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
